// File: rtl/cnn_pkg.sv
// Shared types and size derivations for the convolution feed controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

  // Controller phases: fetch the image, stream beats, let results drain, report.
  typedef enum logic [2:0] {
    IDLE,
    READ,
    STREAM,
    DRAIN,
    FIN
  } state_t;

  // Feeder start timeout is this many padded-image areas.
  localparam int TO_MULT = 4;

  // Wide enough for TO_MULT * 255 * 255 cycles.
  localparam int TO_W = 18;

  // Padded image edge.
  function automatic int i_size(input int size, input int pad);
    return size + 2 * pad;
  endfunction

  // Result edge of a 3x3 valid convolution over the padded image.
  function automatic int o_size(input int size, input int pad);
    return size + 2 * pad - 2;
  endfunction

endpackage

// File: rtl/tag_delay.sv
// Delay line carrying {valid,row,col} result tags from feeder beat to array output.
// Latency: exactly LAT cycles from in_vld to out_vld.
// Backpressure: none; one tag accepted every cycle, invalid tags carry zero coordinates.
module tag_delay
  import cnn_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  input  logic [7:0] in_row,
  input  logic [7:0] in_col,
  output logic       out_vld,
  output logic [7:0] out_row,
  output logic [7:0] out_col
);

  logic [16:0] pipe_q [LAT];
  logic [16:0] pipe_d [LAT];

  // Shift every stage by one; empty slots hold all-zero tags so coordinates stay 0.
  always_comb begin
    pipe_d[0] = in_vld ? {1'b1, in_row, in_col} : 17'd0;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage registers, flushed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= 17'd0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_vld = pipe_q[LAT-1][16];
  assign out_row = pipe_q[LAT-1][15:8];
  assign out_col = pipe_q[LAT-1][7:0];

endmodule

// File: rtl/conv_feed_ctrl.sv
// Reads an image into the feeder, then tracks feeder beats to tag systolic-array results.
// Latency: feed_data 2 cycles after each read; out_valid LAT cycles after its beat.
// Backpressure: none; feeder paces only the stream start, timeout raises sticky err.
module conv_feed_ctrl
  import cnn_pkg::*;
#(
  parameter int SIZE = 7,
  parameter int PAD  = 0,
  parameter int LAT  = 4,
  parameter int AW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata,
  output logic          feed_load,
  output logic [15:0]   feed_data,
  input  logic          feed_srt,
  output logic          out_valid,
  output logic [7:0]    out_row,
  output logic [7:0]    out_col
);

  localparam int I_SZ = i_size(SIZE, PAD);
  localparam int O_SZ = o_size(SIZE, PAD);
  localparam logic [7:0] SZ_M1  = 8'(SIZE - 1);
  localparam logic [7:0] I_M1   = 8'(I_SZ - 1);
  localparam logic [7:0] O_M1   = 8'(O_SZ - 1);
  localparam logic [7:0] LAT_M1 = 8'(LAT - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MULT * I_SZ * I_SZ - 1);
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      rrow_q, rrow_d, rcol_q, rcol_d;
  logic [7:0]      brow_q, brow_d, bcol_q, bcol_d;
  logic [7:0]      dcnt_q, dcnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            srt_seen_q, srt_seen_d;
  logic            err_q, err_d;
  logic            rd_vld_q, rd_vld_d;
  logic            first_q, first_d;
  logic            feed_load_q, feed_load_d;
  logic [15:0]     feed_data_q, feed_data_d;
  logic            beat;
  logic            tag_vld;

  // A beat happens every STREAM cycle from the first sampled feed_srt onward.
  assign beat    = (state_q == STREAM) && (srt_seen_q || feed_srt);
  assign tag_vld = beat && (bcol_q >= 8'd2);

  // Next-state, read sequencing, beat/drain counting and timeout.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rrow_d     = rrow_q;
    rcol_d     = rcol_q;
    brow_d     = brow_q;
    bcol_d     = bcol_q;
    dcnt_d     = dcnt_q;
    to_d       = to_q;
    srt_seen_d = srt_seen_q;
    err_d      = err_q;
    mem_rd     = 1'b0;
    rd_vld_d   = 1'b0;
    first_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          err_d   = 1'b0;
          rrow_d  = 8'd0;
          rcol_d  = 8'd0;
          state_d = READ;
        end
      end
      READ: begin
        mem_rd   = 1'b1;
        rd_vld_d = 1'b1;
        first_d  = (rrow_q == 8'd0) && (rcol_q == 8'd0);
        addr_d   = addr_q + ADDR_ONE;
        if (rcol_q == SZ_M1) begin
          rcol_d = 8'd0;
          if (rrow_q == SZ_M1) begin
            brow_d     = 8'd0;
            bcol_d     = 8'd0;
            to_d       = '0;
            srt_seen_d = 1'b0;
            state_d    = STREAM;
          end else begin
            rrow_d = rrow_q + 8'd1;
          end
        end else begin
          rcol_d = rcol_q + 8'd1;
        end
      end
      STREAM: begin
        if (beat) begin
          srt_seen_d = 1'b1;
          if (bcol_q == I_M1) begin
            bcol_d = 8'd0;
            if (brow_q == O_M1) begin
              dcnt_d  = 8'd0;
              state_d = DRAIN;
            end else begin
              brow_d = brow_q + 8'd1;
            end
          end else begin
            bcol_d = bcol_q + 8'd1;
          end
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == LAT_M1) begin
          state_d = FIN;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data arrives one cycle after the strobe and is registered toward the feeder.
  always_comb begin
    feed_load_d = rd_vld_q && first_q;
    feed_data_d = rd_vld_q ? mem_rdata : feed_data_q;
  end

  // All controller state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rrow_q      <= 8'd0;
      rcol_q      <= 8'd0;
      brow_q      <= 8'd0;
      bcol_q      <= 8'd0;
      dcnt_q      <= 8'd0;
      to_q        <= '0;
      srt_seen_q  <= 1'b0;
      err_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
      first_q     <= 1'b0;
      feed_load_q <= 1'b0;
      feed_data_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rrow_q      <= rrow_d;
      rcol_q      <= rcol_d;
      brow_q      <= brow_d;
      bcol_q      <= bcol_d;
      dcnt_q      <= dcnt_d;
      to_q        <= to_d;
      srt_seen_q  <= srt_seen_d;
      err_q       <= err_d;
      rd_vld_q    <= rd_vld_d;
      first_q     <= first_d;
      feed_load_q <= feed_load_d;
      feed_data_q <= feed_data_d;
    end
  end

  tag_delay #(.LAT(LAT)) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (tag_vld),
    .in_row  (brow_q),
    .in_col  (bcol_q - 8'd2),
    .out_vld (out_valid),
    .out_row (out_row),
    .out_col (out_col)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign mem_addr  = mem_rd ? addr_q : '0;
  assign feed_load = feed_load_q;
  assign feed_data = feed_data_q;

endmodule

// File: doc/conv_feed_ctrl.md
CONV_FEED_CTRL -- requirements
Module: conv_feed_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 7, meaning unpadded image edge length.
REQ-002 SHALL have parameter PAD, default 0, meaning zero-pad width; I_SIZE = SIZE+2*PAD, O_SIZE = I_SIZE-2.
REQ-003 SHALL have parameter LAT, default 4, meaning cycles from a feeder beat to the matching systolic-array result.
REQ-004 SHALL have parameter AW, default 16, meaning image-memory address width.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high (one clock; reset is synchronous and active-high).
REQ-006 SHALL have ports: start in 1 job request; base_addr in AW first pixel address; busy out 1 job active; done out 1 one-cycle completion pulse; err out 1 sticky timeout flag.
REQ-007 SHALL have ports: mem_rd out 1 read strobe; mem_addr out AW read address; mem_rdata in 16 signed pixel, valid one cycle after mem_rd.
REQ-008 SHALL have ports: feed_load out 1 single-cycle load pulse to feeder; feed_data out 16 signed pixel to feeder; feed_srt in 1 feeder start signal.
REQ-009 SHALL have ports: out_valid out 1 result-pixel strobe; out_row out 8; out_col out 8 result coordinates.

Function
REQ-010 SHALL implement FSM states IDLE, READ, STREAM, DRAIN, FIN.
REQ-011 IDLE: start=1 latches base_addr, clears err, goes to READ; busy=1 in every state except IDLE.
REQ-012 start while busy=1 SHALL be ignored.
REQ-013 READ: mem_rd=1 for exactly SIZE*SIZE consecutive cycles, mem_addr = base+k, k = 0..SIZE*SIZE-1 raster order.
REQ-014 feed_data SHALL equal mem_rdata registered, one cycle after each read; feed_load=1 only in the cycle carrying pixel k=0.
REQ-015 After the last read, go to STREAM.
REQ-016 STREAM: on first cycle with feed_srt=1, start beat counter; count I_SIZE*O_SIZE beats, each cycle one beat, beat b -> padded row r=b/I_SIZE, column c=b%I_SIZE.
REQ-017 Beat with c >= 2 SHALL schedule out_valid exactly LAT cycles later with out_row=r, out_col=c-2; others schedule nothing.
REQ-018 Scheduling SHALL use an LAT-deep shift pipeline of {valid,row,col}; no further feed_srt sampling after the last beat.
REQ-019 If feed_srt stays 0 for 4*I_SIZE*I_SIZE cycles after STREAM entry, set err=1 and go to FIN.
REQ-020 After the last beat go to DRAIN; DRAIN lasts LAT cycles so all scheduled out_valid emerge, then FIN.
REQ-021 FIN: done=1 for one cycle, then IDLE; total out_valid pulses per successful job = O_SIZE*O_SIZE.
REQ-022 out_row/out_col SHALL be 0 when out_valid=0.
REQ-023 Counters SHALL be 8 bit; SIZE+2*PAD <= 255 is a legal-config requirement.

Reset
REQ-024 rst=1 at any clock edge, including mid-job, SHALL force IDLE, clear the pipeline and counters, and drive busy, done, err, mem_rd, feed_load, out_valid to 0; mem_addr, feed_data, out_row, out_col to 0.
REQ-025 First start SHALL be accepted on the cycle after rst deasserts.

Structure
REQ-026 State encoding and the I_SIZE/O_SIZE derivation SHALL live in shared package cnn_pkg.
REQ-027 The LAT-deep result-tag delay line SHALL be sub-module tag_delay; all else in one module.

Verification
REQ-028 SIZE=7,PAD=0, base=0x0100, start pulse -> mem_addr 0x0100..0x0130 on 49 consecutive cycles, feed_load one pulse aligned with pixel 0.
REQ-029 Same job, feed_srt high from cycle X -> 25 out_valid, first at X+2+LAT (row 0, col 0), last (4,4), then done one pulse after DRAIN.
REQ-030 SIZE=7,PAD=1 -> 49 reads, 63 beats counted, 49 out_valid, coordinates 0..6.
REQ-031 feed_srt held 0 -> err=1 after 324 STREAM cycles, done pulses, zero out_valid.
REQ-032 start asserted mid-READ -> ignored, addresses unchanged; rst asserted mid-STREAM -> all outputs 0 next cycle, new start then runs a clean job.
